// File: rtl/console_sched.sv
// Frame scheduler: after a host config it reloads the tick generator, then reads NUM_CH ADC channels on each tick edge.
// Optional ack timeout is enabled by defining CONSOLE_SCHED_TIMEOUT_EN.
module console_sched #(
  parameter int NUM_CH   = 8,
  parameter int CONF_LEN = 4,
  parameter int ACK_TO   = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cfg_vld,
  input  logic [3:0] cfg_fsamp,
  output logic       cfg_rdy,
  output logic       fs_conf,
  output logic [3:0] fsamp,
  input  logic       tick,
  output logic       adc_req,
  output logic [3:0] adc_ch,
  input  logic       adc_ack,
  output logic       frame_done,
  output logic       overrun,
  output logic       err_to,
  output logic [2:0] state_dbg
);

  // Handshakes: a config transfers on a cycle with cfg_vld && cfg_rdy; a channel
  // transfers on a cycle with adc_req && adc_ack. Holders keep valid/req asserted until then.

  if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
    $error("console_sched: NUM_CH out of range");
  end
  if (CONF_LEN < 1) begin : g_bad_conf_len
    $error("console_sched: CONF_LEN must be at least 1");
  end
  if (ACK_TO < 1 || ACK_TO > 65535) begin : g_bad_ack_to
    $error("console_sched: ACK_TO out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CONF = 3'd1,
    S_ARM  = 3'd2,
    S_WAIT = 3'd3,
    S_REQ  = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t      state, state_nxt;
  logic        tick_d, tick_rise;
  logic        cfg_acc, overrun_set, to_hit;
  logic [3:0]  ch, ch_nxt;
  logic [15:0] conf_cnt, conf_cnt_nxt;

  assign tick_rise = tick & ~tick_d;

`ifdef CONSOLE_SCHED_TIMEOUT_EN
  logic [15:0] to_cnt;

  // Cleared outside REQ, so every entry to REQ starts from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           to_cnt <= '0;
    else if (state != S_REQ || adc_ack) to_cnt <= '0;
    else                               to_cnt <= to_cnt + 16'd1;
  end

  assign to_hit = (state == S_REQ) && !adc_ack && (to_cnt == 16'(ACK_TO - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         err_to <= 1'b0;
    else if (cfg_acc) err_to <= 1'b0;
    else if (to_hit)  err_to <= 1'b1;
  end
`else
  assign to_hit = 1'b0;
  assign err_to = 1'b0;
`endif

  always_comb begin
    state_nxt    = state;
    ch_nxt       = ch;
    conf_cnt_nxt = conf_cnt;
    cfg_acc      = 1'b0;
    overrun_set  = 1'b0;
    case (state)
      S_IDLE: begin
        if (cfg_vld) begin
          cfg_acc      = 1'b1;
          conf_cnt_nxt = '0;
          state_nxt    = S_CONF;
        end
      end
      S_CONF: begin
        if (conf_cnt == 16'(CONF_LEN - 1)) state_nxt = S_ARM;
        else                               conf_cnt_nxt = conf_cnt + 16'd1;
      end
      S_ARM: state_nxt = S_WAIT;
      S_WAIT: begin
        // A config arriving with a tick edge wins; that edge is simply dropped.
        if (cfg_vld) begin
          cfg_acc      = 1'b1;
          conf_cnt_nxt = '0;
          state_nxt    = S_CONF;
        end else if (tick_rise) begin
          ch_nxt    = '0;
          state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        overrun_set = tick_rise;
        if (adc_ack) begin
          if (ch == 4'(NUM_CH - 1)) state_nxt = S_DONE;
          else                      ch_nxt = ch + 4'd1;
        end else if (to_hit) begin
          ch_nxt    = '0;
          state_nxt = S_WAIT;
        end
      end
      S_DONE: begin
        overrun_set = tick_rise;
        state_nxt   = S_WAIT;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      ch       <= '0;
      conf_cnt <= '0;
      tick_d   <= 1'b1;
      fsamp    <= '0;
      overrun  <= 1'b0;
    end else begin
      state    <= state_nxt;
      ch       <= ch_nxt;
      conf_cnt <= conf_cnt_nxt;
      tick_d   <= tick;
      if (cfg_acc)          fsamp <= cfg_fsamp;
      if (cfg_acc)          overrun <= 1'b0;
      else if (overrun_set) overrun <= 1'b1;
    end
  end

  // Outputs decode the state register only, so reset takes them down immediately.
  assign cfg_rdy    = (state == S_IDLE) || (state == S_WAIT);
  assign fs_conf    = (state == S_CONF);
  assign adc_req    = (state == S_REQ);
  assign adc_ch     = adc_req ? ch : 4'd0;
  assign frame_done = (state == S_DONE);
  assign state_dbg  = state;

endmodule

// File: tb/tb_console_sched.sv
// Self-checking bench for console_sched: table of config/frame vectors plus hand-written corner sequences.
module tb_console_sched;

  localparam int NUM_CH   = 8;
  localparam int CONF_LEN = 4;
  localparam int ACK_TO   = 1000;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_vld;
  logic [3:0] cfg_fsamp;
  logic       cfg_rdy;
  logic       fs_conf;
  logic [3:0] fsamp;
  logic       tick;
  logic       adc_req;
  logic [3:0] adc_ch;
  logic       adc_ack;
  logic       frame_done;
  logic       overrun;
  logic       err_to;
  logic [2:0] state_dbg;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  console_sched #(.NUM_CH(NUM_CH), .CONF_LEN(CONF_LEN), .ACK_TO(ACK_TO)) dut (
    .clk(clk), .rst(rst), .cfg_vld(cfg_vld), .cfg_fsamp(cfg_fsamp), .cfg_rdy(cfg_rdy),
    .fs_conf(fs_conf), .fsamp(fsamp), .tick(tick), .adc_req(adc_req), .adc_ch(adc_ch),
    .adc_ack(adc_ack), .frame_done(frame_done), .overrun(overrun), .err_to(err_to),
    .state_dbg(state_dbg)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int fd_cnt  = 0;
  logic [3:0] exp_q[$];

  typedef struct {
    logic [3:0] fsamp_in;
    bit         rand_ack;
    logic [3:0] exp_fsamp;
    int         exp_conf;
    int         exp_rdy_low;
  } vec_t;
  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_done) fd_cnt++;
      if (!adc_req) check("adc_ch_zero_when_idle", 32'(adc_ch), 32'd0);
      if (adc_req && adc_ack) begin
        if (exp_q.size() == 0) check("unexpected_transfer", 32'(adc_ch), 32'hFFFF);
        else                   check("xfer_ch", 32'(adc_ch), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame();
    for (int c = 0; c < NUM_CH; c++) exp_q.push_back(4'(c));
  endtask

  task automatic do_config(input logic [3:0] f, output int conf_n, output int rdy_low_n, output bit ok);
    int guard = 0;
    cfg_fsamp = f;
    cfg_vld   = 1'b1;
    while (!cfg_rdy && guard < 50) begin
      step();
      guard++;
    end
    step();
    ok        = (guard < 50);
    cfg_vld   = 1'b0;
    cfg_fsamp = 4'($urandom_range(0, 15));
    conf_n    = 0;
    rdy_low_n = 0;
    for (int i = 0; i < CONF_LEN + 6; i++) begin
      if (fs_conf)  conf_n++;
      if (!cfg_rdy) rdy_low_n++;
      step();
    end
  endtask

  task automatic run_frame(input bit rand_ack);
    int guard = 0;
    int fd0   = fd_cnt;
    bit seen  = 1'b0;
    push_frame();
    tick = 1'b1;
    while (!seen && guard < 300) begin
      adc_ack = rand_ack ? 1'($urandom_range(0, 1)) : 1'b1;
      step();
      seen = frame_done;
      guard++;
    end
    check("frame_done_seen", 32'(seen), 32'd1);
    adc_ack = 1'b0;
    tick    = 1'b0;
    step();
    check("frame_done_one_cycle", 32'(frame_done), 32'd0);
    check("back_in_wait_rdy", 32'(cfg_rdy), 32'd1);
    check("frame_count", 32'(fd_cnt - fd0), 32'd1);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // ---------------- main test ----------------
  initial begin
    int  conf_n, rdy_low_n, req_n, seen_req, fd0, guard;
    bit  ok;

    vecs[0] = '{fsamp_in: 4'h1, rand_ack: 1'b0, exp_fsamp: 4'h1, exp_conf: CONF_LEN, exp_rdy_low: CONF_LEN + 1};
    vecs[1] = '{fsamp_in: 4'hA, rand_ack: 1'b1, exp_fsamp: 4'hA, exp_conf: CONF_LEN, exp_rdy_low: CONF_LEN + 1};
    vecs[2] = '{fsamp_in: 4'hF, rand_ack: 1'b1, exp_fsamp: 4'hF, exp_conf: CONF_LEN, exp_rdy_low: CONF_LEN + 1};
    vecs[3] = '{fsamp_in: 4'h0, rand_ack: 1'b0, exp_fsamp: 4'h0, exp_conf: CONF_LEN, exp_rdy_low: CONF_LEN + 1};

    rst = 1'b1; cfg_vld = 1'b0; cfg_fsamp = 4'h7; tick = 1'b0; adc_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_fsamp", 32'(fsamp), 32'd0);
    check("rst_fs_conf", 32'(fs_conf), 32'd0);
    check("rst_adc_req", 32'(adc_req), 32'd0);
    check("rst_adc_ch", 32'(adc_ch), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_err_to", 32'(err_to), 32'd0);
    check("rst_cfg_rdy", 32'(cfg_rdy), 32'd1);
    rst = 1'b0;
    step();

    // Tick edges before the first config are ignored.
    seen_req = 0;
    tick = 1'b1;
    repeat (4) begin step(); if (adc_req) seen_req++; end
    check("idle_ignores_tick", 32'(seen_req), 32'd0);
    tick = 1'b0;
    step();

    for (int v = 0; v < 4; v++) begin
      do_config(vecs[v].fsamp_in, conf_n, rdy_low_n, ok);
      check("cfg_accepted", 32'(ok), 32'd1);
      check("cfg_fsamp_latched", 32'(fsamp), 32'(vecs[v].exp_fsamp));
      check("cfg_fs_conf_len", 32'(conf_n), 32'(vecs[v].exp_conf));
      check("cfg_rdy_low_len", 32'(rdy_low_n), 32'(vecs[v].exp_rdy_low));
      run_frame(vecs[v].rand_ack);
      check("vec_no_overrun", 32'(overrun), 32'd0);
    end

    // Back-to-back channel stepping with ack held high.
    push_frame();
    tick = 1'b1; adc_ack = 1'b1;
    step();
    check("req_cycle_after_edge", 32'(adc_req), 32'd1);
    for (int k = 0; k < NUM_CH; k++) begin
      check("seq_adc_ch", 32'(adc_ch), 32'(k));
      step();
    end
    check("seq_frame_done", 32'(frame_done), 32'd1);
    adc_ack = 1'b0; tick = 1'b0;
    step();
    check("seq_frame_done_drop", 32'(frame_done), 32'd0);
    check("seq_wait_rdy", 32'(cfg_rdy), 32'd1);

    // Second edge mid-frame: overrun set, frame continues.
    push_frame();
    tick = 1'b1; adc_ack = 1'b0;
    step();
    tick = 1'b0; step();
    tick = 1'b1; step();
    check("ovr_set", 32'(overrun), 32'd1);
    check("ovr_still_req", 32'(adc_req), 32'd1);
    check("ovr_ch_kept", 32'(adc_ch), 32'd0);
    adc_ack = 1'b1;
    guard = 0;
    while (!frame_done && guard < 50) begin step(); guard++; end
    check("ovr_frame_completes", 32'(frame_done), 32'd1);
    adc_ack = 1'b0;
    step();
    check("ovr_sticky", 32'(overrun), 32'd1);
    check("ovr_scoreboard", 32'(exp_q.size()), 32'd0);
    tick = 1'b0;
    step();
    do_config(4'h5, conf_n, rdy_low_n, ok);
    check("ovr_cleared_by_cfg", 32'(overrun), 32'd0);
    check("ovr_cfg_fsamp", 32'(fsamp), 32'd5);

    // Config and tick edge in the same WAIT cycle.
    cfg_vld = 1'b1; cfg_fsamp = 4'h3; tick = 1'b1;
    step();
    cfg_vld = 1'b0;
    check("coinc_conf_entered", 32'(fs_conf), 32'd1);
    seen_req = adc_req ? 1 : 0;
    repeat (CONF_LEN + 6) begin step(); if (adc_req) seen_req++; end
    check("coinc_no_req", 32'(seen_req), 32'd0);
    check("coinc_no_overrun", 32'(overrun), 32'd0);
    check("coinc_fsamp", 32'(fsamp), 32'd3);
    tick = 1'b0;
    step();

    // Ack stuck low.
    push_frame();
    fd0 = fd_cnt;
    tick = 1'b1; adc_ack = 1'b0;
    step();
    req_n = 0;
    while (adc_req && req_n < ACK_TO + 100) begin req_n++; step(); end
`ifdef CONSOLE_SCHED_TIMEOUT_EN
    check("to_req_cycles", 32'(req_n), 32'(ACK_TO));
    check("to_err_set", 32'(err_to), 32'd1);
    check("to_no_frame_done", 32'(fd_cnt - fd0), 32'd0);
    check("to_back_in_wait", 32'(cfg_rdy), 32'd1);
    exp_q.delete();
    tick = 1'b0;
    step();
    run_frame(1'b0);
    check("to_err_sticky", 32'(err_to), 32'd1);
    do_config(4'h2, conf_n, rdy_low_n, ok);
    check("to_err_cleared", 32'(err_to), 32'd0);
`else
    check("noto_still_waiting", 32'(req_n), 32'(ACK_TO + 100));
    check("noto_err_zero", 32'(err_to), 32'd0);
    check("noto_no_frame_done", 32'(fd_cnt - fd0), 32'd0);
    adc_ack = 1'b1;
    guard = 0;
    while (!frame_done && guard < 50) begin step(); guard++; end
    check("noto_frame_completes", 32'(frame_done), 32'd1);
    adc_ack = 1'b0; tick = 1'b0;
    step();
    check("noto_scoreboard", 32'(exp_q.size()), 32'd0);
`endif

    // Reset in the middle of a frame.
    push_frame();
    tick = 1'b1; adc_ack = 1'b1;
    step();
    guard = 0;
    while (adc_ch != 4'd3 && guard < 20) begin step(); guard++; end
    check("mid_reached_ch3", 32'(adc_ch), 32'd3);
    fd0 = fd_cnt;
    rst = 1'b1; adc_ack = 1'b0;
    #1;
    check("mid_rst_adc_req", 32'(adc_req), 32'd0);
    check("mid_rst_adc_ch", 32'(adc_ch), 32'd0);
    check("mid_rst_fsamp", 32'(fsamp), 32'd0);
    check("mid_rst_fs_conf", 32'(fs_conf), 32'd0);
    check("mid_rst_frame_done", 32'(frame_done), 32'd0);
    check("mid_rst_overrun", 32'(overrun), 32'd0);
    check("mid_rst_err_to", 32'(err_to), 32'd0);
    check("mid_rst_cfg_rdy", 32'(cfg_rdy), 32'd1);
    exp_q.delete();
    step(); step();
    rst = 1'b0; tick = 1'b0;
    step();
    tick = 1'b1;
    seen_req = 0;
    repeat (5) begin step(); if (adc_req) seen_req++; end
    check("post_rst_tick_ignored", 32'(seen_req), 32'd0);
    check("post_rst_no_frame_done", 32'(fd_cnt - fd0), 32'd0);
    tick = 1'b0;
    step();
    do_config(4'h9, conf_n, rdy_low_n, ok);
    check("post_rst_cfg_fsamp", 32'(fsamp), 32'd9);
    check("post_rst_fs_conf_len", 32'(conf_n), 32'(CONF_LEN));
    run_frame(1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
